dec_scan: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable.
- Two modes:
  - direct: an external select is accepted over a valid/ready handshake.
  - scan: an internal counter steps through all outputs with a programmable dwell time.
- Sits between lab control logic and multiplexed loads such as 7-segment digit anodes and LED banks. It replaces hand-cascaded 2x4 decoder-with-enable structures.

---
 rtl/dec_scan_pkg.sv | 31 +++
 rtl/dec_scan_if.sv | 17 +
 rtl/dec_scan_onehot.sv | 21 ++
 rtl/dec_scan.sv | 118 +++++++++++
 tb/tb_dec_scan.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: shared definitions for the dec_scan one-hot decoder.
//   - MODE_DIRECT / MODE_SCAN : values of the dec_scan mode input
//   - state_t                 : FSM state encoding (BLANK is reached only when
//                               DEC_SCAN_BLANK_GAP_EN is defined)
//   - onehot(sel, en)         : full-width (2^MAX_SEL_W) one-hot decode with
//                               enable; callers truncate to their output width
package dec_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Largest supported select width; the decode helper is sized for it.
  localparam int MAX_SEL_W = 5;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2,
    BLANK  = 2'd3
  } state_t;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input logic                 en);
    logic [MAX_OUT_W-1:0] v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_scan_if.sv
// dec_scan_if: select handshake between a controller and dec_scan.
//   sel_valid : controller offers sel
//   sel       : requested output index
//   sel_ready : decoder accepts sel this cycle
// Modports: master (controller side), slave (decoder side).
interface dec_scan_if #(
  parameter int SEL_W = 2
);

  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             sel_ready;

  modport master (output sel_valid, output sel, input  sel_ready);
  modport slave  (input  sel_valid, input  sel, output sel_ready);

endinterface

// File: rtl/dec_scan_onehot.sv
// dec_onehot: combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
//   sel : index to decode
//   en  : 0 forces all outputs low
//   y   : one-hot result (active high)
module dec_onehot
  import dec_scan_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  output logic [(1<<SEL_W)-1:0]   y
);

  localparam int OUT_W = 1 << SEL_W;

  // Decode at the package's maximum width, then keep the low OUT_W bits;
  // sel < 2^SEL_W guarantees the hot bit lands inside the kept slice.
  assign y = OUT_W'(onehot(MAX_SEL_W'(sel), en));

endmodule

// File: rtl/dec_scan.sv
// dec_scan: registered N-to-2^N one-hot decoder with enable and two modes.
//   direct (mode=0): sel is taken over the sel_valid/sel_ready handshake and
//                    decoded onto y one cycle after the transfer.
//   scan   (mode=1): an internal index steps through all outputs, each held
//                    for DWELL cycles; wrap pulses when the index returns to 0.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   en         : global enable (0 -> all outputs inactive, IDLE)
//   mode       : MODE_DIRECT / MODE_SCAN
//   sel_if     : dec_scan_if.slave (sel_valid, sel, sel_ready)
//   y          : registered one-hot (one-cold when ACTIVE_LOW=1) output
//   idx        : index currently driven
//   wrap       : one-cycle pulse on scan wrap from 2^SEL_W-1 to 0
// Optional feature macro: DEC_SCAN_BLANK_GAP_EN inserts one all-inactive
// BLANK cycle at every scan advance (anti-ghosting for multiplexed displays).
module dec_scan
  import dec_scan_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  dec_scan_if.slave             sel_if,
  output logic [(1<<SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int                OUT_W      = 1 << SEL_W;
  localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [OUT_W-1:0]  Y_OFF      = ACTIVE_LOW ? '1 : '0;

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic [DW_W-1:0]  dwell_reg, dwell_next;
  logic [OUT_W-1:0] y_reg, y_next, hot_next;
  logic             wrap_reg, wrap_next;
  logic             drive_next;

  // Ready follows the current inputs so that a mode change and sel_valid
  // arriving together are judged by the new mode.
  assign sel_if.sel_ready = en && (mode == MODE_DIRECT);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    dwell_next = dwell_reg;
    wrap_next  = 1'b0;
    drive_next = 1'b0;

    if (!en) begin
      // Outputs go inactive; idx and the dwell counter keep their values.
      state_next = IDLE;
    end else if (mode == MODE_DIRECT) begin
      state_next = DIRECT;
      drive_next = 1'b1;
      // Leaving DIRECT for SCAN must start a fresh dwell from the current idx.
      dwell_next = '0;
      if (sel_if.sel_valid && sel_if.sel_ready) idx_next = sel_if.sel;
    end else begin
      state_next = SCAN;
      drive_next = 1'b1;
      if (state_reg == IDLE || state_reg == BLANK) begin
        // y is (re)driven on this edge, so the dwell starts here at 0.
        dwell_next = '0;
      end else if (dwell_reg == DWELL_LAST) begin
        dwell_next = '0;
        idx_next   = idx_reg + 1'b1;
        wrap_next  = (idx_reg == '1);
`ifdef DEC_SCAN_BLANK_GAP_EN
        // One dark cycle with the new idx already visible; the new output
        // lights on the following edge.
        state_next = BLANK;
        drive_next = 1'b0;
`endif
      end else begin
        dwell_next = dwell_reg + 1'b1;
      end
    end
  end

  dec_onehot #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel (idx_next),
    .en  (drive_next),
    .y   (hot_next)
  );

  // Polarity is applied only here, right before the output register.
  assign y_next = ACTIVE_LOW ? ~hot_next : hot_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      dwell_reg <= '0;
      y_reg     <= Y_OFF;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      dwell_reg <= dwell_next;
      y_reg     <= y_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign y    = y_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: directed self-checking bench for dec_scan (SEL_W=2, DWELL=3).
// Two instances share the stimulus: dut0 with ACTIVE_LOW=0, dut1 with
// ACTIVE_LOW=1. With DEC_SCAN_BLANK_GAP_EN defined, the scan section checks
// the blank-gap sequence on dut1 instead of the plain scan sequence.
module tb_dec_scan;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       sel_valid;
  logic [1:0] sel;

  logic [3:0] y0, y1;
  logic [1:0] idx0, idx1;
  logic       wrap0, wrap1;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] dir_y   [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] scan_y  [13] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
                               4'b1000, 4'b0001, 4'b0001};
  logic [3:0] blank_y [16] = '{4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101,
                               4'b1101, 4'b1111, 4'b1011, 4'b1011, 4'b1011,
                               4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b1111,
                               4'b1110};

  dec_scan_if #(.SEL_W(2)) bus0 ();
  dec_scan_if #(.SEL_W(2)) bus1 ();

  assign bus0.sel_valid = sel_valid;
  assign bus0.sel       = sel;
  assign bus1.sel_valid = sel_valid;
  assign bus1.sel       = sel;

  dec_scan #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(1'b0)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .sel_if (bus0),
    .y      (y0),
    .idx    (idx0),
    .wrap   (wrap0)
  );

  dec_scan #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(1'b1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .sel_if (bus1),
    .y      (y1),
    .idx    (idx1),
    .wrap   (wrap1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 2'd0;

    // Reset
    tick(2);
    check("rst_y",    y0,    4'b0000);
    check("rst_idx",  idx0,  2'd0);
    check("rst_wrap", wrap0, 1'b0);
    check("rst_y_al", y1,    4'b1111);
    rst_n = 1'b1;
    tick(1);
    check("idle_y",   y0,             4'b0000);
    check("idle_rdy", bus0.sel_ready, 1'b0);

    // Direct sweep
    en = 1'b1; mode = 1'b0; sel_valid = 1'b1;
    #1;
    check("dir_rdy", bus0.sel_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick(1);
      check("dir_y",   y0,   dir_y[i]);
      check("dir_idx", idx0, 32'(i));
    end
    check("dir_y_al", y1, 4'b0111);
    sel_valid = 1'b0; sel = 2'd1;
    tick(2);
    check("dir_hold_y",   y0,   4'b1000);
    check("dir_hold_idx", idx0, 2'd3);

`ifndef DEC_SCAN_BLANK_GAP_EN
    // Scan wrap from idx 0; sel is offered but must be ignored
    sel_valid = 1'b1; sel = 2'd0;
    tick(1);
    check("scan_pre_y", y0, 4'b0001);
    mode = 1'b1; sel = 2'd2;
    #1;
    check("scan_rdy", bus0.sel_ready, 1'b0);
    for (int e = 0; e < 13; e++) begin
      tick(1);
      check("scan_y",    y0,    scan_y[e]);
      check("scan_wrap", wrap0, (e == 11) ? 1'b1 : 1'b0);
    end

    // Enable gating mid-scan at idx 2
    tick(5);
    check("gate_pre_y",   y0,   4'b0100);
    check("gate_pre_idx", idx0, 2'd2);
    en = 1'b0;
    tick(1);
    check("gate_off_y",    y0,   4'b0000);
    check("gate_off_idx",  idx0, 2'd2);
    check("gate_off_y_al", y1,   4'b1111);
    tick(1);
    check("gate_idle_y", y0, 4'b0000);
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      check("gate_on_y", y0, 4'b0100);
    end
    tick(1);
    check("gate_next_y",   y0,   4'b1000);
    check("gate_next_idx", idx0, 2'd3);

    // Mode switch scan -> direct at idx 1
    tick(6);
    check("sw_pre_y",   y0,   4'b0010);
    check("sw_pre_idx", idx0, 2'd1);
    mode = 1'b0; sel_valid = 1'b0;
    tick(2);
    check("sw_hold_y",    y0, 4'b0010);
    check("sw_hold_y_al", y1, 4'b1101);
    sel_valid = 1'b1; sel = 2'd3;
    tick(1);
    check("sw_sel_y", y0, 4'b1000);
    // Mode change and sel_valid together: scan mode wins, sel ignored
    mode = 1'b1; sel = 2'd0;
    tick(1);
    check("sw_scan_idx", idx0, 2'd3);
    check("sw_scan_y",   y0,   4'b1000);
`else
    // Blank-gap scan on the active-low instance: 16-cycle period
    sel_valid = 1'b1; sel = 2'd0;
    tick(1);
    check("blank_pre_y", y1, 4'b1110);
    mode = 1'b1; sel_valid = 1'b0;
    for (int e = 0; e < 16; e++) begin
      tick(1);
      check("blank_y",    y1,    blank_y[e]);
      check("blank_wrap", wrap1, (e == 14) ? 1'b1 : 1'b0);
      if (e == 2) check("blank_idx", idx1, 2'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
